// File: rtl/xif_copro_issue_ctrl.sv
// XIF coprocessor issue controller: decodes bit-manipulation offloads, waits for commit,
// drives a single-request execution unit and returns the result on the XIF result channel.
module xif_copro_issue_ctrl #(
   parameter int ID_WIDTH = 4,
   parameter int XLEN     = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic [31:0]         issue_instr_i,
   input  logic [ID_WIDTH-1:0] issue_id_i,
   input  logic [XLEN-1:0]     issue_rs1_i,
   input  logic                issue_rs1_valid_i,
   output logic                issue_accept_o,
   output logic                issue_writeback_o,
   input  logic                commit_valid_i,
   input  logic [ID_WIDTH-1:0] commit_id_i,
   input  logic                commit_kill_i,
   output logic                exu_req_valid_o,
   input  logic                exu_req_ready_i,
   output logic [1:0]          exu_op_o,
   output logic [XLEN-1:0]     exu_operand_o,
   output logic [4:0]          exu_shamt_o,
   input  logic                exu_rsp_valid_i,
   input  logic [XLEN-1:0]     exu_result_i,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [ID_WIDTH-1:0] result_id_o,
   output logic [XLEN-1:0]     result_data_o,
   output logic [15:0]         done_count_o
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_COMMIT,
      EXEC,
      WAIT_EXU,
      RESULT
   } state_e;

   localparam logic [1:0] OP_BITREV = 2'b00;
   localparam logic [1:0] OP_ROTR   = 2'b01;
   localparam logic [1:0] OP_ROTL   = 2'b10;

   state_e              state_q, state_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [XLEN-1:0]     operand_q, operand_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [1:0]          op_q, op_d;
   logic [4:0]          shamt_q, shamt_d;
   logic [15:0]         count_q, count_d;

   logic       dec_legal;
   logic [1:0] dec_op;
   logic       issue_hs;
   logic       instr_unused;

   assign instr_unused = ^{issue_instr_i[19:15], issue_instr_i[11:7]};

   always_comb begin
      dec_legal = 1'b0;
      dec_op    = OP_BITREV;
      if (issue_instr_i[6:0] == 7'b0101011 && issue_instr_i[14:12] == 3'b111) begin
         case (issue_instr_i[31:25])
            7'b0000010: begin dec_legal = 1'b1; dec_op = OP_BITREV; end
            7'b0000011: begin dec_legal = 1'b1; dec_op = OP_ROTR;   end
            7'b0000100: begin dec_legal = 1'b1; dec_op = OP_ROTL;   end
            default:    begin dec_legal = 1'b0; dec_op = OP_BITREV; end
         endcase
      end
   end

   // Combinational handshake outputs are gated by reset so every output reads 0 while rst_i is high.
   assign issue_ready_o     = (state_q == IDLE) && issue_rs1_valid_i && !rst_i;
   assign issue_accept_o    = dec_legal && !rst_i;
   assign issue_writeback_o = dec_legal && !rst_i;
   assign issue_hs          = issue_valid_i && issue_ready_o;

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      operand_d = operand_q;
      result_d  = result_q;
      op_d      = op_q;
      shamt_d   = shamt_q;
      count_d   = count_q;
      case (state_q)
         IDLE: begin
            if (issue_hs && dec_legal) begin
               id_d      = issue_id_i;
               operand_d = issue_rs1_i;
               op_d      = dec_op;
               shamt_d   = (dec_op == OP_BITREV) ? 5'd0 : issue_instr_i[24:20];
               state_d   = WAIT_COMMIT;
            end
         end
         WAIT_COMMIT: begin
            if (commit_valid_i && commit_id_i == id_q) begin
               state_d = commit_kill_i ? IDLE : EXEC;
            end
         end
         EXEC: begin
            if (exu_req_ready_i) begin
               state_d = WAIT_EXU;
            end
         end
         WAIT_EXU: begin
            if (exu_rsp_valid_i) begin
               result_d = exu_result_i;
               state_d  = RESULT;
            end
         end
         RESULT: begin
            if (result_ready_i) begin
               count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         id_q      <= '0;
         operand_q <= '0;
         result_q  <= '0;
         op_q      <= '0;
         shamt_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         operand_q <= operand_d;
         result_q  <= result_d;
         op_q      <= op_d;
         shamt_q   <= shamt_d;
         count_q   <= count_d;
      end
   end

   assign exu_req_valid_o = (state_q == EXEC);
   assign exu_op_o        = op_q;
   assign exu_operand_o   = operand_q;
   assign exu_shamt_o     = shamt_q;
   assign result_valid_o  = (state_q == RESULT);
   assign result_id_o     = id_q;
   assign result_data_o   = result_q;
   assign done_count_o    = count_q;

endmodule

// File: tb/tb_xif_copro_issue_ctrl.sv
// Bench for xif_copro_issue_ctrl: decode vector table through the full flow with a result
// scoreboard, plus hand-written kill, backpressure and reset sequences.
module tb_xif_copro_issue_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        issue_valid_i;
   logic        issue_ready_o;
   logic [31:0] issue_instr_i;
   logic [3:0]  issue_id_i;
   logic [31:0] issue_rs1_i;
   logic        issue_rs1_valid_i;
   logic        issue_accept_o;
   logic        issue_writeback_o;
   logic        commit_valid_i;
   logic [3:0]  commit_id_i;
   logic        commit_kill_i;
   logic        exu_req_valid_o;
   logic        exu_req_ready_i;
   logic [1:0]  exu_op_o;
   logic [31:0] exu_operand_o;
   logic [4:0]  exu_shamt_o;
   logic        exu_rsp_valid_i;
   logic [31:0] exu_result_i;
   logic        result_valid_o;
   logic        result_ready_i;
   logic [3:0]  result_id_o;
   logic [31:0] result_data_o;
   logic [15:0] done_count_o;

   xif_copro_issue_ctrl #(.ID_WIDTH(4), .XLEN(32)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .issue_valid_i     (issue_valid_i),
      .issue_ready_o     (issue_ready_o),
      .issue_instr_i     (issue_instr_i),
      .issue_id_i        (issue_id_i),
      .issue_rs1_i       (issue_rs1_i),
      .issue_rs1_valid_i (issue_rs1_valid_i),
      .issue_accept_o    (issue_accept_o),
      .issue_writeback_o (issue_writeback_o),
      .commit_valid_i    (commit_valid_i),
      .commit_id_i       (commit_id_i),
      .commit_kill_i     (commit_kill_i),
      .exu_req_valid_o   (exu_req_valid_o),
      .exu_req_ready_i   (exu_req_ready_i),
      .exu_op_o          (exu_op_o),
      .exu_operand_o     (exu_operand_o),
      .exu_shamt_o       (exu_shamt_o),
      .exu_rsp_valid_i   (exu_rsp_valid_i),
      .exu_result_i      (exu_result_i),
      .result_valid_o    (result_valid_o),
      .result_ready_i    (result_ready_i),
      .result_id_o       (result_id_o),
      .result_data_o     (result_data_o),
      .done_count_o      (done_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  id;
      logic [31:0] rs1;
      logic        acc;
      logic [1:0]  op;
      logic [4:0]  sh;
   } vec_t;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
   } exp_t;

   vec_t        vecs[9];
   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          exu_hs_cnt = 0;
   logic [15:0] exp_count;
   logic [31:0] last_rs1;

   always @(posedge clk_i) begin
      if (exu_req_valid_o && exu_req_ready_i) exu_hs_cnt <= exu_hs_cnt + 1;
   end

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] sh,
                                       input logic [2:0] f3, input logic [6:0] opc);
      return {f7, sh, 5'd1, f3, 5'd2, opc};
   endfunction

   function automatic logic [31:0] exu_model(input logic [1:0] op, input logic [31:0] x,
                                             input logic [4:0] sh);
      logic [31:0] r;
      logic [63:0] w;
      r = '0;
      w = {x, x};
      case (op)
         2'b00: for (int i = 0; i < 32; i++) r[i] = x[31-i];
         2'b01: r = 32'(w >> sh);
         2'b10: begin w = w << sh; r = w[63:32]; end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_issue(input logic [31:0] instr, input logic [3:0] id,
                           input logic [31:0] rs1, input logic exp_acc);
      issue_instr_i     = instr;
      issue_id_i        = id;
      issue_rs1_i       = rs1;
      issue_rs1_valid_i = 1'b1;
      issue_valid_i     = 1'b1;
      #1;
      check("issue_ready_idle", 64'(issue_ready_o), 64'(1'b1));
      check("issue_accept", 64'(issue_accept_o), 64'(exp_acc));
      check("issue_writeback", 64'(issue_writeback_o), 64'(exp_acc));
      if (exp_acc) last_rs1 = rs1;
      tick();
      issue_valid_i = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] id, input logic kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      tick();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
   endtask

   // EXU model: accepts the request immediately and answers one cycle later from what it was sent.
   task automatic do_exu();
      logic [1:0]  rop;
      logic [31:0] rx;
      logic [4:0]  rsh;
      rop = exu_op_o;
      rx  = exu_operand_o;
      rsh = exu_shamt_o;
      exu_req_ready_i = 1'b1;
      tick();
      exu_req_ready_i = 1'b0;
      check("exu_req_dropped", 64'(exu_req_valid_o), 64'(1'b0));
      exu_rsp_valid_i = 1'b1;
      exu_result_i    = exu_model(rop, rx, rsh);
      tick();
      exu_rsp_valid_i = 1'b0;
   endtask

   task automatic pop_compare();
      exp_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: result produced with 0 entries expected");
      end else begin
         e = sb.pop_front();
         check("result_id", 64'(result_id_o), 64'(e.id));
         check("result_data", 64'(result_data_o), 64'(e.data));
      end
   endtask

   task automatic take_result();
      check("result_valid", 64'(result_valid_o), 64'(1'b1));
      pop_compare();
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      exp_count = exp_count + 16'd1;
      check("result_valid_clr", 64'(result_valid_o), 64'(1'b0));
      check("done_count", 64'(done_count_o), 64'(exp_count));
      check("ready_after_result", 64'(issue_ready_o), 64'(1'b1));
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      if (v.acc) begin
         e.id   = v.id;
         e.data = exu_model(v.op, v.rs1, v.sh);
         sb.push_back(e);
      end
      do_issue(v.instr, v.id, v.rs1, v.acc);
      if (!v.acc) begin
         check("rej_stays_idle", 64'(issue_ready_o), 64'(1'b1));
         check("rej_no_exu", 64'(exu_req_valid_o), 64'(1'b0));
         check("rej_no_latch", 64'(exu_operand_o), 64'(last_rs1));
         tick();
         check("rej_no_exu_later", 64'(exu_req_valid_o), 64'(1'b0));
         return;
      end
      check("wc_not_ready", 64'(issue_ready_o), 64'(1'b0));
      check("wc_no_exu", 64'(exu_req_valid_o), 64'(1'b0));
      do_commit(v.id, 1'b0);
      check("exec_req_valid", 64'(exu_req_valid_o), 64'(1'b1));
      check("exec_op", 64'(exu_op_o), 64'(v.op));
      check("exec_shamt", 64'(exu_shamt_o), 64'(v.sh));
      check("exec_operand", 64'(exu_operand_o), 64'(v.rs1));
      do_exu();
      take_result();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached without finishing");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      int   hs0;
      rst_i             = 1'b1;
      issue_valid_i     = 1'b0;
      issue_instr_i     = enc(7'h02, 5'd0, 3'b111, 7'h2B);
      issue_id_i        = '0;
      issue_rs1_i       = '0;
      issue_rs1_valid_i = 1'b1;
      commit_valid_i    = 1'b0;
      commit_id_i       = '0;
      commit_kill_i     = 1'b0;
      exu_req_ready_i   = 1'b0;
      exu_rsp_valid_i   = 1'b0;
      exu_result_i      = '0;
      result_ready_i    = 1'b0;
      exp_count         = '0;
      last_rs1          = '0;

      vecs[0] = '{enc(7'h02, 5'd7,  3'b111, 7'h2B), 4'd1,  32'h0000_0001, 1'b1, 2'b00, 5'd0};
      vecs[1] = '{enc(7'h03, 5'd8,  3'b111, 7'h2B), 4'd5,  32'h1234_5678, 1'b1, 2'b01, 5'd8};
      vecs[2] = '{32'h0000_706B,                    4'd2,  32'hFFFF_FFFF, 1'b0, 2'b00, 5'd0};
      vecs[3] = '{enc(7'h04, 5'd4,  3'b111, 7'h2B), 4'd7,  32'hF000_0001, 1'b1, 2'b10, 5'd4};
      vecs[4] = '{enc(7'h02, 5'd0,  3'b110, 7'h2B), 4'd4,  32'h0BAD_0BAD, 1'b0, 2'b00, 5'd0};
      vecs[5] = '{enc(7'h03, 5'd0,  3'b111, 7'h2B), 4'd15, 32'hDEAD_BEEF, 1'b1, 2'b01, 5'd0};
      vecs[6] = '{enc(7'h03, 5'd1,  3'b111, 7'h2F), 4'd8,  32'h0000_0F00, 1'b0, 2'b00, 5'd0};
      vecs[7] = '{enc(7'h04, 5'd31, 3'b111, 7'h2B), 4'd0,  32'h8000_0003, 1'b1, 2'b10, 5'd31};
      vecs[8] = '{enc(7'h05, 5'd2,  3'b111, 7'h2B), 4'd9,  32'h5555_AAAA, 1'b0, 2'b00, 5'd0};

      #2;
      check("rst_issue_ready", 64'(issue_ready_o), 64'(1'b0));
      check("rst_accept", 64'(issue_accept_o), 64'(1'b0));
      check("rst_exu_req", 64'(exu_req_valid_o), 64'(1'b0));
      check("rst_result_valid", 64'(result_valid_o), 64'(1'b0));
      check("rst_operand", 64'(exu_operand_o), 64'(32'h0));
      check("rst_done_count", 64'(done_count_o), 64'(16'h0));
      #20;
      rst_i = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);
      check("bitrev_expected", 64'(exu_model(2'b00, 32'h1, 5'd0)), 64'(32'h8000_0000));

      // Killed ROTLEFT: the mismatched ID 2 commit must not end WAIT_COMMIT.
      do_issue(enc(7'h04, 5'd4, 3'b111, 7'h2B), 4'd3, 32'h1111_2222, 1'b1);
      check("kill_latched_op", 64'(exu_op_o), 64'(2'b10));
      check("kill_latched_shamt", 64'(exu_shamt_o), 64'(5'd4));
      do_commit(4'd2, 1'b1);
      check("kill_id2_ignored_ready", 64'(issue_ready_o), 64'(1'b0));
      check("kill_id2_no_exu", 64'(exu_req_valid_o), 64'(1'b0));
      do_commit(4'd3, 1'b1);
      check("kill_back_idle", 64'(issue_ready_o), 64'(1'b1));
      check("kill_no_exu", 64'(exu_req_valid_o), 64'(1'b0));
      tick();
      check("kill_no_result", 64'(result_valid_o), 64'(1'b0));
      check("kill_count_same", 64'(done_count_o), 64'(exp_count));

      // EXU backpressure for 5 cycles.
      e.id   = 4'd9;
      e.data = exu_model(2'b01, 32'hA5A5_0F0F, 5'd12);
      sb.push_back(e);
      do_issue(enc(7'h03, 5'd12, 3'b111, 7'h2B), 4'd9, 32'hA5A5_0F0F, 1'b1);
      do_commit(4'd9, 1'b0);
      hs0 = exu_hs_cnt;
      for (int c = 0; c < 5; c++) begin
         check("bp_req_valid", 64'(exu_req_valid_o), 64'(1'b1));
         check("bp_op", 64'(exu_op_o), 64'(2'b01));
         check("bp_shamt", 64'(exu_shamt_o), 64'(5'd12));
         check("bp_operand", 64'(exu_operand_o), 64'(32'hA5A5_0F0F));
         tick();
      end
      do_exu();
      check("bp_single_request", 64'(exu_hs_cnt), 64'(hs0 + 1));
      take_result();

      // Result backpressure with an (illegal) issue held valid the whole time.
      e.id   = 4'd6;
      e.data = exu_model(2'b10, 32'h8000_0001, 5'd1);
      sb.push_back(e);
      do_issue(enc(7'h04, 5'd1, 3'b111, 7'h2B), 4'd6, 32'h8000_0001, 1'b1);
      issue_instr_i = 32'h0000_706B;
      issue_valid_i = 1'b1;
      do_commit(4'd6, 1'b0);
      do_exu();
      for (int c = 0; c < 3; c++) begin
         check("rbp_result_valid", 64'(result_valid_o), 64'(1'b1));
         check("rbp_result_id", 64'(result_id_o), 64'(4'd6));
         check("rbp_result_data", 64'(result_data_o), 64'(e.data));
         check("rbp_issue_blocked", 64'(issue_ready_o), 64'(1'b0));
         tick();
      end
      pop_compare();
      result_ready_i = 1'b1;
      #1;
      check("rbp_blocked_at_hs", 64'(issue_ready_o), 64'(1'b0));
      tick();
      result_ready_i = 1'b0;
      exp_count = exp_count + 16'd1;
      check("rbp_ready_after_hs", 64'(issue_ready_o), 64'(1'b1));
      check("rbp_done_count", 64'(done_count_o), 64'(exp_count));
      tick();
      issue_valid_i = 1'b0;
      check("rbp_idle_no_exu", 64'(exu_req_valid_o), 64'(1'b0));

      // Asynchronous reset while waiting on the EXU.
      e.id   = 4'd12;
      e.data = 32'h0;
      sb.push_back(e);
      do_issue(enc(7'h03, 5'd3, 3'b111, 7'h2B), 4'd12, 32'h0F0F_0F0F, 1'b1);
      do_commit(4'd12, 1'b0);
      exu_req_ready_i = 1'b1;
      tick();
      exu_req_ready_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      sb.delete();
      exp_count = '0;
      last_rs1  = '0;
      check("mrst_exu_req", 64'(exu_req_valid_o), 64'(1'b0));
      check("mrst_operand", 64'(exu_operand_o), 64'(32'h0));
      check("mrst_op_shamt", 64'({exu_op_o, exu_shamt_o}), 64'(7'h0));
      check("mrst_result", 64'({result_valid_o, result_id_o, result_data_o}), 64'(37'h0));
      check("mrst_count", 64'(done_count_o), 64'(16'h0));
      check("mrst_accept", 64'({issue_accept_o, issue_writeback_o, issue_ready_o}), 64'(3'b000));
      #2;
      rst_i = 1'b0;
      exu_rsp_valid_i = 1'b1;
      exu_result_i    = 32'hCAFE_F00D;
      tick();
      exu_rsp_valid_i = 1'b0;
      check("mrst_rsp_ignored", 64'(result_valid_o), 64'(1'b0));
      check("mrst_result_data", 64'(result_data_o), 64'(32'h0));
      check("mrst_idle", 64'(issue_ready_o), 64'(1'b1));
      tick();
      check("mrst_still_no_result", 64'(result_valid_o), 64'(1'b0));
      check("mrst_count_zero", 64'(done_count_o), 64'(16'h0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xif_copro_issue_ctrl.md
XIF_COPRO_ISSUE_CTRL -- requirements
Module: xif_copro_issue_ctrl

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, the XIF instruction-ID width.
REQ-002 SHALL have parameter XLEN, default 32, the operand and result width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port issue_valid_i, input, 1, offload request valid.
REQ-006 SHALL have port issue_ready_o, output, 1, offload request ready.
REQ-007 SHALL have port issue_instr_i, input, 32, offloaded instruction word.
REQ-008 SHALL have port issue_id_i, input, ID_WIDTH, offloaded instruction ID.
REQ-009 SHALL have port issue_rs1_i, input, XLEN, rs1 operand.
REQ-010 SHALL have port issue_rs1_valid_i, input, 1, rs1 operand valid.
REQ-011 SHALL have port issue_accept_o, input-qualified output, 1, accept response, valid during the issue handshake.
REQ-012 SHALL have port issue_writeback_o, output, 1, writeback response, valid during the issue handshake.
REQ-013 SHALL have port commit_valid_i, input, 1, commit strobe.
REQ-014 SHALL have port commit_id_i, input, ID_WIDTH, ID being committed.
REQ-015 SHALL have port commit_kill_i, input, 1, kill flag for the committed ID.
REQ-016 SHALL have ports exu_req_valid_o (output, 1) and exu_req_ready_i (input, 1), the execution-unit request handshake.
REQ-017 SHALL have ports exu_op_o (output, 2; 00 BITREV, 01 ROTRIGHT, 10 ROTLEFT), exu_operand_o (output, XLEN), and exu_shamt_o (output, 5).
REQ-018 SHALL have ports exu_rsp_valid_i (input, 1) and exu_result_i (input, XLEN), the execution-unit response.
REQ-019 SHALL have ports result_valid_o (output, 1), result_ready_i (input, 1), result_id_o (output, ID_WIDTH), and result_data_o (output, XLEN), the XIF result channel.
REQ-020 SHALL have port done_count_o, output, 16, count of completed instructions.

Function
REQ-021 SHALL decode as follows.
- Opcode 0101011 with funct3 111 is required for every instruction.
- funct7 0000010 decodes to BITREV.
- funct7 0000011 decodes to ROTRIGHT.
- funct7 0000100 decodes to ROTLEFT.
- All other encodings are rejected.
REQ-022 SHALL implement the FSM states IDLE, WAIT_COMMIT, EXEC, WAIT_EXU and RESULT.
REQ-023 SHALL drive issue_ready_o = 1 only in IDLE with issue_rs1_valid_i = 1.
REQ-024 SHALL drive issue_accept_o and issue_writeback_o combinationally from the decode result, with both at 1 for a legal instruction and both at 0 for an illegal one.
REQ-025 On an accepted issue handshake, SHALL latch the ID, operand, op, and shamt (instr[24:20]; 0 for BITREV), then move to WAIT_COMMIT.
REQ-026 On a rejected issue handshake, SHALL remain in IDLE and latch nothing.
REQ-027 SHALL sample commit only in WAIT_COMMIT; a commit arriving in the same cycle as the issue handshake SHALL be ignored.
REQ-028 In WAIT_COMMIT, a commit with a matching ID and kill=1 SHALL return the FSM to IDLE; with kill=0 it SHALL move to EXEC; a commit with a non-matching ID SHALL be ignored.
REQ-029 In EXEC, SHALL hold exu_req_valid_o = 1 with stable exu_op_o, exu_operand_o and exu_shamt_o until exu_req_ready_i = 1, then move to WAIT_EXU.
REQ-030 In WAIT_EXU, on exu_rsp_valid_i = 1, SHALL latch exu_result_i and move to RESULT; exu_rsp_valid_i in any other state SHALL be ignored.
REQ-031 In RESULT, SHALL hold result_valid_o = 1 with stable result_id_o and result_data_o until result_ready_i = 1, then return to IDLE.
REQ-032 SHALL permit no new issue before the IDLE cycle that follows the result handshake (one instruction in flight at a time).
REQ-033 SHALL increment done_count_o by 1 on each result handshake, saturating at 0xFFFF; a killed instruction SHALL NOT be counted.
REQ-034 Minimum latency: issue in cycle N, commit in N+1, exu_req_valid_o in N+2, and result_valid_o in the cycle after exu_rsp_valid_i.

Reset
REQ-035 While rst_i = 1 (asserted asynchronously), SHALL hold the FSM in IDLE and drive all outputs and latched registers to 0.
REQ-036 Reset mid-operation SHALL discard the in-flight instruction with no result and no count increment.

Verification
REQ-037 Bench SHALL cover: issue BITREV with rs1 = 0x00000001, then commit with kill=0 -> exu_op_o = 00, then exu response 0x80000000 -> result_data_o = 0x80000000, done_count_o = 1.
REQ-038 Bench SHALL cover: issue instr 0x0000706B (funct7 0000000) -> issue_accept_o = 0, FSM stays IDLE, no exu_req_valid_o.
REQ-039 Bench SHALL cover: issue ROTLEFT with shamt = 4 and ID 3, then commit ID 2 followed by ID 3 with kill=1 -> the ID 2 commit is ignored, FSM returns to IDLE, no result, count unchanged.
REQ-040 Bench SHALL cover: exu_req_ready_i held low for 5 cycles -> exu_req_valid_o and the request fields stay stable, and the request is sent exactly once.
REQ-041 Bench SHALL cover: result_ready_i held low for 3 cycles, with issue_valid_i held high throughout -> issue_ready_o = 0 until the cycle after the result handshake.
REQ-042 Bench SHALL cover: rst_i asserted in WAIT_EXU -> outputs go to 0 immediately, and a subsequent exu_rsp_valid_i is ignored.
